xc_aessub_iter: RTL and testbench
=================================

XC_AESSUB_ITER -- requirements
Module: xc_aessub_iter

Interface
REQ-001 Parameter SBOXES, default 1, meaning S-box instances evaluated per cycle; the legal values are 1, 2 and 4.
REQ-002 Port g_clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port g_resetn, input, 1, reset; reset SHALL be synchronous and active-low.
REQ-004 Port flush, input, 1, abort of any in-flight operation.
REQ-005 Port valid, input, 1, request; it SHALL stay high until ready is seen.
REQ-006 Port rs1, input, 32, source operand 1.
REQ-007 Port rs2, input, 32, source operand 2.
REQ-008 Port enc, input, 1, forward S-box when 1 and inverse S-box when 0.
REQ-009 Port rot, input, 1, rotate the result left by 8 bits when 1.
REQ-010 Port ready, output, 1, one-cycle completion pulse.
REQ-011 Port busy, output, 1, high whenever state is not IDLE.
REQ-012 Port result, output, 32, substituted word; it SHALL be valid only while ready=1.

Function
REQ-013 The selected word SHALL be t = {rs2[31:24], rs1[23:16], rs2[15:8], rs1[7:0]}.
REQ-014 Each byte s[i] SHALL be sbox(t[i]) when enc=1 and inv_sbox(t[i]) when enc=0.
REQ-015 result SHALL be {s3,s2,s1,s0} when rot=0 and {s2,s1,s0,s3} when rot=1.
REQ-016 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-017 In IDLE with valid=1 and flush=0, the block SHALL capture t, enc and rot into registers, clear the group counter, and go to BUSY.
REQ-018 Each BUSY cycle SHALL substitute bytes [cnt*SBOXES +: SBOXES] into the result register and increment cnt.
REQ-019 On the BUSY cycle that handles the last group (cnt = 4/SBOXES-1), the FSM SHALL go to DONE.
REQ-020 In DONE, ready SHALL be 1, result SHALL show the assembled and rotated word, and the next state SHALL be IDLE.
REQ-021 Latency SHALL be 4/SBOXES+1 cycles from the acceptance edge to ready: 5, 3 or 2 cycles.
REQ-022 Operands SHALL be sampled only at acceptance; later changes to rs1, rs2, enc or rot SHALL not affect the operation in flight.
REQ-023 flush=1 in any state SHALL force IDLE on the next edge with ready=0; no result SHALL be produced for the aborted operation.
REQ-024 If valid falls during BUSY, the block SHALL treat it as flush.
REQ-025 flush and valid both high in IDLE SHALL not start an operation.
REQ-026 The cycle after DONE is IDLE; if valid is still high there, a new operation SHALL start.
REQ-027 Outside DONE, ready SHALL be 0 and result SHALL be 32'h0.
REQ-028 cnt SHALL be ceil(log2(4/SBOXES)) bits wide, minimum 1 bit, and SHALL never wrap while in BUSY.

Reset
REQ-029 When g_resetn=0 at a rising edge, the block SHALL set state to IDLE, and cnt, the result register and the captured t, enc and rot to 0.
REQ-030 During reset and the first cycle after it, ready and busy SHALL be 0 and result SHALL be 32'h0.
REQ-031 Reset asserted mid-operation SHALL discard the operation and emit no ready pulse.

Structure
REQ-032 Package xc_aessub_pkg SHALL hold the state enum (IDLE/BUSY/DONE), the byte-select function for t, and the rotate function.
REQ-033 The block SHALL instantiate SBOXES copies of the combinational sub-module xc_aes_sbox (ports: in[7:0], enc, out[7:0]; forward and inverse tables).
REQ-034 The implementation SHALL be 120-400 lines of RTL and SHALL contain no combinational path from inputs to ready or result.

Verification
REQ-035 Encrypt, no rotate: SBOXES=1, rs1=32'h0, rs2=32'h53535353, enc=1, rot=0 -> ready exactly 5 cycles after acceptance, result=32'hED63ED63.
REQ-036 Encrypt with rotate: same operands, rot=1, SBOXES=4 -> ready after 2 cycles, result=32'h63ED63ED.
REQ-037 Decrypt: rs1=32'h63636363, rs2=32'hEDEDEDED, enc=0, rot=0, SBOXES=2 -> ready after 3 cycles, result=32'h53005300.
REQ-038 Flush: flush=1 during the 2nd BUSY cycle (SBOXES=1) -> no ready pulse; a new request rs1=rs2=32'h01010101, enc=1 -> result=32'h7C7C7C7C.
REQ-039 Back-to-back and operand change: valid held high across DONE -> second ready 5 cycles after IDLE (SBOXES=1); changing rs1 mid-BUSY -> first result unchanged.
REQ-040 Reset: g_resetn=0 in BUSY -> next cycle ready=0, busy=0, result=32'h0, and no later spurious ready pulse.

Source files
------------

// File: rtl/xc_aessub_pkg.sv
// Shared types and helpers for the iterative AES byte-substitution block:
// FSM states, operand byte selection and the optional 8-bit left rotate.
package xc_aessub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Odd bytes come from rs2, even bytes from rs1.
  function automatic logic [31:0] sel_word(input logic [31:0] rs1, input logic [31:0] rs2);
    return (rs2 & 32'hFF00_FF00) | (rs1 & 32'h00FF_00FF);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w, input logic rot);
    return rot ? {w[23:0], w[31:24]} : w;
  endfunction

endpackage

// File: rtl/xc_aes_sbox.sv
// Combinational AES S-box: forward table when enc=1, inverse table when enc=0.
// Tables are stored with entry 0 in the most significant byte.
module xc_aes_sbox (
  input  logic [7:0] in,
  input  logic       enc,
  output logic [7:0] out
);

  localparam logic [2047:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  logic [10:0] idx;

  assign idx = 11'd2047 - {in, 3'b000};
  assign out = enc ? FWD[idx -: 8] : INV[idx -: 8];

endmodule

// File: rtl/xc_aessub_iter.sv
// Iterative AES SubWord unit: substitutes SBOXES bytes per cycle through a
// shared S-box bank, then presents the (optionally rotated) word for one cycle.
module xc_aessub_iter
  import xc_aessub_pkg::*;
#(
  parameter int SBOXES = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        flush,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  input  logic        rot,
  output logic        ready,
  output logic        busy,
  output logic [31:0] result
);

  localparam int NGRP  = 4 / SBOXES;
  localparam int CNT_W = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NGRP - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        t_q, res_q, res_d;
  logic               enc_q, rot_q, capture;
  logic [SBOXES*8-1:0] sbox_in, sbox_out;

  always_comb begin
    sbox_in = '0;
    for (int g = 0; g < SBOXES; g++)
      sbox_in[g*8 +: 8] = t_q[5'((int'(cnt_q) * SBOXES + g) * 8) +: 8];
  end

  for (genvar g = 0; g < SBOXES; g++) begin : g_sbox
    xc_aes_sbox u_sbox (
      .in  (sbox_in[g*8 +: 8]),
      .enc (enc_q),
      .out (sbox_out[g*8 +: 8])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid && !flush) begin
          capture = 1'b1;
          cnt_d   = '0;
          res_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A dropped request is an abort, just like flush.
        if (!valid) begin
          state_d = IDLE;
        end else begin
          for (int g = 0; g < SBOXES; g++)
            res_d[5'((int'(cnt_q) * SBOXES + g) * 8) +: 8] = sbox_out[g*8 +: 8];
          if (cnt_q == LAST) state_d = DONE;
          else               cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      t_q     <= '0;
      enc_q   <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      if (capture) begin
        t_q   <= sel_word(rs1, rs2);
        enc_q <= enc;
        rot_q <= rot;
      end
    end
  end

  // Outputs depend on registered state only.
  assign ready  = (state_q == DONE);
  assign busy   = (state_q != IDLE);
  assign result = ready ? rot_word(res_q, rot_q) : 32'h0;

endmodule

// File: tb/tb_xc_aessub_iter.sv
// Bench for xc_aessub_iter: three instances (SBOXES = 1, 2, 4) checked against
// an S-box model built from GF(2^8) inversion plus the affine transform.
module tb_xc_aessub_iter;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        flush [3];
  logic        valid [3];
  logic        enc   [3];
  logic        rot   [3];
  logic [31:0] rs1   [3];
  logic [31:0] rs2   [3];
  logic        ready [3];
  logic        busy  [3];
  logic [31:0] result[3];

  logic [7:0]  sb_t  [256];
  logic [7:0]  isb_t [256];
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 g_clk = ~g_clk;

  xc_aessub_iter #(.SBOXES(1)) dut1 (.g_clk(g_clk), .g_resetn(g_resetn), .flush(flush[0]),
    .valid(valid[0]), .rs1(rs1[0]), .rs2(rs2[0]), .enc(enc[0]), .rot(rot[0]),
    .ready(ready[0]), .busy(busy[0]), .result(result[0]));
  xc_aessub_iter #(.SBOXES(2)) dut2 (.g_clk(g_clk), .g_resetn(g_resetn), .flush(flush[1]),
    .valid(valid[1]), .rs1(rs1[1]), .rs2(rs2[1]), .enc(enc[1]), .rot(rot[1]),
    .ready(ready[1]), .busy(busy[1]), .result(result[1]));
  xc_aessub_iter #(.SBOXES(4)) dut4 (.g_clk(g_clk), .g_resetn(g_resetn), .flush(flush[2]),
    .valid(valid[2]), .rs1(rs1[2]), .rs2(rs2[2]), .enc(enc[2]), .rot(rot[2]),
    .ready(ready[2]), .busy(busy[2]), .result(result[2]));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(x), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb_t[x]  = s;
      isb_t[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic e, input logic r);
    logic [7:0] t [4];
    logic [7:0] s [4];
    logic [31:0] w;
    t[3] = b[31:24]; t[2] = a[23:16]; t[1] = b[15:8]; t[0] = a[7:0];
    for (int i = 0; i < 4; i++) s[i] = e ? sb_t[t[i]] : isb_t[t[i]];
    w = {s[3], s[2], s[1], s[0]};
    return r ? {w[23:0], w[31:24]} : w;
  endfunction

  function automatic int lat_of(input int k);
    return 4 / (1 << k) + 1;
  endfunction

  // One request on instance k; optionally scrambles the operand inputs after acceptance.
  task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic e, input logic r, input bit scramble,
                       input logic [31:0] exp, input string tag);
    int n; bit seen;
    rs1[k] = a; rs2[k] = b; enc[k] = e; rot[k] = r; flush[k] = 1'b0; valid[k] = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(posedge g_clk); #1; n++;
      if (scramble) begin
        rs1[k] = $urandom; rs2[k] = $urandom; enc[k] = 1'($urandom); rot[k] = 1'($urandom);
      end
      if (ready[k]) seen = 1;
      else begin
        n_cmp++;
        if (result[k] !== 32'h0 || busy[k] !== 1'b1) begin
          n_fail++;
          $display("FAIL %s k=%0d in-flight: result=%h busy=%b, required result=0 busy=1",
                   tag, k, result[k], busy[k]);
        end
      end
    end
    valid[k] = 1'b0;
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s k=%0d timeout: no ready within 20 cycles", tag, k);
    end else begin
      if (result[k] !== exp) begin
        n_fail++;
        $display("FAIL %s k=%0d result: got %h, required %h", tag, k, result[k], exp);
      end
      n_cmp++;
      if (n !== lat_of(k)) begin
        n_fail++;
        $display("FAIL %s k=%0d latency: got %0d, required %0d", tag, k, n, lat_of(k));
      end
    end
  endtask

  task automatic watch_no_ready(input int cycles, input string tag);
    int pulses;
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge g_clk); #1;
      for (int k = 0; k < 3; k++) if (ready[k]) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL %s spurious ready: got %0d pulses, required 0", tag, pulses);
    end
  endtask

  task automatic test_reset();
    g_resetn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      flush[k] = 0; valid[k] = 0; enc[k] = 0; rot[k] = 0; rs1[k] = '0; rs2[k] = '0;
    end
    repeat (2) @(posedge g_clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (ready[k] !== 1'b0 || busy[k] !== 1'b0 || result[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_hold k=%0d: ready=%b busy=%b result=%h, required 0/0/0",
                 k, ready[k], busy[k], result[k]);
      end
    end
    g_resetn = 1'b1;
    @(posedge g_clk); #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (ready[k] !== 1'b0 || busy[k] !== 1'b0 || result[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_after k=%0d: ready=%b busy=%b result=%h, required 0/0/0",
                 k, ready[k], busy[k], result[k]);
      end
    end
  endtask

  task automatic test_directed();
    do_op(0, 32'h0, 32'h53535353, 1'b1, 1'b0, 0, 32'hED63ED63, "enc_norot");
    do_op(2, 32'h0, 32'h53535353, 1'b1, 1'b1, 0, 32'h63ED63ED, "enc_rot");
    do_op(1, 32'h63636363, 32'hEDEDEDED, 1'b0, 1'b0, 0, 32'h53005300, "dec");
  endtask

  task automatic test_random();
    logic [31:0] a, b; logic e, r;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) begin
        a = $urandom; b = $urandom; e = 1'($urandom); r = 1'($urandom);
        do_op(k, a, b, e, r, bit'(i[0]), ref_op(a, b, e, r), "random");
        @(posedge g_clk); #1;
      end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      rs1[k] = $urandom; rs2[k] = $urandom; enc[k] = 1'b1; valid[k] = 1'b1;
      @(posedge g_clk); #1;
      if (k == 0) begin @(posedge g_clk); #1; end
      flush[k] = 1'b1; valid[k] = 1'b0;
      @(posedge g_clk); #1;
      flush[k] = 1'b0;
      n_cmp++;
      if (ready[k] !== 1'b0 || busy[k] !== 1'b0 || result[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL flush k=%0d: ready=%b busy=%b result=%h, required 0/0/0",
                 k, ready[k], busy[k], result[k]);
      end
      watch_no_ready(8, "flush");
    end
    do_op(0, 32'h01010101, 32'h01010101, 1'b1, 1'b0, 0, 32'h7C7C7C7C, "after_flush");
    @(posedge g_clk); #1;
    // Request withdrawn mid-operation.
    rs1[0] = $urandom; valid[0] = 1'b1;
    repeat (2) @(posedge g_clk);
    #1; valid[0] = 1'b0;
    @(posedge g_clk); #1;
    n_cmp++;
    if (busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_drop busy: got %b, required 0", busy[0]);
    end
    watch_no_ready(8, "valid_drop");
    // flush together with valid in IDLE must not start anything.
    for (int k = 0; k < 3; k++) begin valid[k] = 1'b1; flush[k] = 1'b1; end
    for (int c = 0; c < 3; c++) begin
      @(posedge g_clk); #1;
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (busy[k] !== 1'b0 || ready[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_idle k=%0d: busy=%b ready=%b, required 0/0", k, busy[k], ready[k]);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin valid[k] = 1'b0; flush[k] = 1'b0; end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, e1, e2;
    int n; bit seen;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    e1 = ref_op(a1, b1, 1'b1, 1'b0);
    e2 = ref_op(a2, b2, 1'b0, 1'b1);
    rs1[0] = a1; rs2[0] = b1; enc[0] = 1'b1; rot[0] = 1'b0; valid[0] = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(posedge g_clk); #1; n++;
      if (n == 2) rs1[0] = ~a1;
      if (ready[0]) seen = 1;
    end
    n_cmp++;
    if (!seen || result[0] !== e1 || n !== 5) begin
      n_fail++;
      $display("FAIL b2b_first: seen=%0d result=%h lat=%0d, required result=%h lat=5",
               seen, result[0], n, e1);
    end
    rs1[0] = a2; rs2[0] = b2; enc[0] = 1'b0; rot[0] = 1'b1;
    @(posedge g_clk); #1;
    n_cmp++;
    if (busy[0] !== 1'b0 || ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: busy=%b ready=%b, required 0/0", busy[0], ready[0]);
    end
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(posedge g_clk); #1; n++;
      if (ready[0]) seen = 1;
    end
    valid[0] = 1'b0;
    n_cmp++;
    if (!seen || result[0] !== e2 || n !== 5) begin
      n_fail++;
      $display("FAIL b2b_second: seen=%0d result=%h lat=%0d, required result=%h lat=5",
               seen, result[0], n, e2);
    end
    repeat (2) @(posedge g_clk);
    #1;
    n_cmp++;
    if (busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end busy: got %b, required 0", busy[0]);
    end
  endtask

  task automatic test_reset_mid();
    rs1[0] = $urandom; rs2[0] = $urandom; enc[0] = 1'b1; valid[0] = 1'b1;
    repeat (2) @(posedge g_clk);
    #1;
    g_resetn = 1'b0; valid[0] = 1'b0;
    @(posedge g_clk); #1;
    n_cmp++;
    if (ready[0] !== 1'b0 || busy[0] !== 1'b0 || result[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: ready=%b busy=%b result=%h, required 0/0/0",
               ready[0], busy[0], result[0]);
    end
    g_resetn = 1'b1;
    watch_no_ready(8, "reset_mid");
  endtask

  initial begin
    build_tables();
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
